// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-strobe input bundle and key-event valid/ready stream of the PS/2 key event controller.
// master is the controller's view; slave is the receiver/game-logic view.
interface ps2_key_event_ctrl_if;
  logic       CODE_VALID;
  logic [7:0] CODE_IN;
  logic       CODE_ERR;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [7:0] EVT_CODE;
  logic       EVT_EXT;
  logic       EVT_REL;

  modport master (
    input  CODE_VALID, CODE_IN, CODE_ERR, EVT_READY,
    output EVT_VALID, EVT_CODE, EVT_EXT, EVT_REL
  );

  modport slave (
    output CODE_VALID, CODE_IN, CODE_ERR, EVT_READY,
    input  EVT_VALID, EVT_CODE, EVT_EXT, EVT_REL
  );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// Turns PS/2 scan-byte strobes (E0/F0 prefixes + codes) into press/release events,
// tracks held game keys and queues events in a first-word fall-through FIFO.
module ps2_key_event_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT       = 50000,
  parameter int unsigned FILTER_REPEAT = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ps2_key_event_ctrl_if.master bus,
  output logic                 KEY_LEFT,
  output logic                 KEY_RIGHT,
  output logic                 KEY_FIRE,
  output logic                 KEY_PAUSE,
  output logic                 OVERFLOW,
  output logic                 PROTO_ERR
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } evt_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic          byte_ok, byte_bad, is_ext, is_brk, timeout;
  logic          cmp, cmp_ext, cmp_rel, err;
  logic          map_hit, push;
  logic [1:0]    map_idx;
  logic [3:0]    keys;

  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          valid, full, pop, wr_en;
  evt_t          head;

  assign byte_ok  = bus.CODE_VALID & ~bus.CODE_ERR;
  assign byte_bad = bus.CODE_VALID & bus.CODE_ERR;
  assign is_ext   = (bus.CODE_IN == PFX_EXT);
  assign is_brk   = (bus.CODE_IN == PFX_BRK);
  assign timeout  = (state != IDLE) && !bus.CODE_VALID && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET || state == IDLE || bus.CODE_VALID || timeout) tcnt <= '0;
    else                                                     tcnt <= tcnt + TW'(1);
  end

  always_comb begin
    state_nxt = state;
    cmp       = 1'b0;
    cmp_ext   = 1'b0;
    cmp_rel   = 1'b0;
    err       = 1'b0;
    if (byte_bad) begin
      state_nxt = IDLE;
      err       = 1'b1;
    end else if (byte_ok) begin
      case (state)
        IDLE: begin
          if (is_ext)      state_nxt = EXT;
          else if (is_brk) state_nxt = BRK;
          else             cmp = 1'b1;
        end
        EXT: begin
          if (is_brk)      state_nxt = EXT_BRK;
          else if (is_ext) err = 1'b1;
          else begin
            cmp       = 1'b1;
            cmp_ext   = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          state_nxt = IDLE;
          if (is_ext || is_brk) err = 1'b1;
          else begin
            cmp     = 1'b1;
            cmp_ext = (state == EXT_BRK);
            cmp_rel = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
      err       = 1'b1;
    end
  end

  always_comb begin
    map_hit = 1'b1;
    map_idx = 2'd0;
    case ({cmp_ext, bus.CODE_IN})
      {1'b1, 8'h6B}: map_idx = 2'd0;
      {1'b1, 8'h74}: map_idx = 2'd1;
      {1'b0, 8'h29}: map_idx = 2'd2;
      {1'b0, 8'h4D}: map_idx = 2'd3;
      default:       map_hit = 1'b0;
    endcase
    // Typematic repeats of an already-held mapped key are swallowed when filtering.
    push = cmp && !(FILTER_REPEAT != 0 && map_hit && !cmp_rel && keys[map_idx]);
  end

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop   = valid & bus.EVT_READY;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      keys      <= '0;
      PROTO_ERR <= 1'b0;
      OVERFLOW  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      PROTO_ERR <= err;
      if (cmp && map_hit)      keys[map_idx] <= ~cmp_rel;
      if (push && full && !pop) OVERFLOW <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= {bus.CODE_IN, cmp_ext, cmp_rel};
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign head          = mem[rd_ptr];
  assign bus.EVT_VALID = valid;
  assign bus.EVT_CODE  = valid ? head.code : '0;
  assign bus.EVT_EXT   = valid & head.ext;
  assign bus.EVT_REL   = valid & head.rel;

  assign KEY_LEFT  = keys[0];
  assign KEY_RIGHT = keys[1];
  assign KEY_FIRE  = keys[2];
  assign KEY_PAUSE = keys[3];
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed and random byte streams checked every cycle against a prefix-list reference model;
// a second instance with repeat filtering disabled shares the input stream.
module tb_ps2_key_event_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 400;

  logic CLK = 1'b0;
  logic RESET;
  logic rdy;
  logic l0, r0, f0, p0, ov0, pe0;
  logic l1, r1, f1, p1, ov1, pe1;
  int   checks = 0;
  int   fails  = 0;
  int   obs0   = 0;
  int   obs1   = 0;

  ps2_key_event_ctrl_if bus ();
  ps2_key_event_ctrl_if bus1 ();

  ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .FILTER_REPEAT(1)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .KEY_LEFT(l0), .KEY_RIGHT(r0), .KEY_FIRE(f0), .KEY_PAUSE(p0),
    .OVERFLOW(ov0), .PROTO_ERR(pe0)
  );

  ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .FILTER_REPEAT(0)) dut_nf (
    .CLK(CLK), .RESET(RESET), .bus(bus1),
    .KEY_LEFT(l1), .KEY_RIGHT(r1), .KEY_FIRE(f1), .KEY_PAUSE(p1),
    .OVERFLOW(ov1), .PROTO_ERR(pe1)
  );

  assign bus1.CODE_VALID = bus.CODE_VALID;
  assign bus1.CODE_IN    = bus.CODE_IN;
  assign bus1.CODE_ERR   = bus.CODE_ERR;
  assign bus1.EVT_READY  = 1'b1;

  always #5 CLK = ~CLK;

  // Reference model: pending prefix bytes as a list, held keys, event queue.
  logic [7:0] pfx[$];
  logic [9:0] fq[$];
  int         qcnt = 0;
  bit         held[4];
  bit         ovf = 0, perr = 0, x1_v = 0;
  logic [9:0] x1_e;

  function automatic int key_idx(input bit ext, input logic [7:0] c);
    if (ext && c == 8'h6B)  return 0;
    if (ext && c == 8'h74)  return 1;
    if (!ext && c == 8'h29) return 2;
    if (!ext && c == 8'h4D) return 3;
    return -1;
  endfunction

  task automatic model_step(input bit v, input logic [7:0] c, input bit e, input bit rd, input bit r);
    bit cmp = 0, ext = 0, rel = 0, pop, push0;
    int k;
    if (r) begin
      pfx.delete(); fq.delete();
      qcnt = 0; ovf = 0; perr = 0; x1_v = 0;
      for (int i = 0; i < 4; i++) held[i] = 0;
      return;
    end
    perr = 0;
    if (v && e) begin
      perr = 1;
      pfx.delete();
    end else if (v) begin
      if (c == 8'hE0 || c == 8'hF0) begin
        pfx.push_back(c);
        if (!(pfx.size() == 1 || (pfx.size() == 2 && pfx[0] == 8'hE0 && pfx[1] == 8'hF0))) begin
          perr = 1;
          if (pfx.size() == 2 && pfx[0] == 8'hE0 && pfx[1] == 8'hE0) begin
            pfx.delete(); pfx.push_back(8'hE0);
          end else pfx.delete();
        end
      end else begin
        cmp = 1;
        ext = (pfx.size() > 0 && pfx[0] == 8'hE0);
        rel = (pfx.size() > 0 && pfx[pfx.size()-1] == 8'hF0);
        pfx.delete();
      end
    end
    if (v || pfx.size() == 0) qcnt = 0;
    else begin
      qcnt++;
      if (qcnt == int'(TMO)) begin
        perr = 1; pfx.delete(); qcnt = 0;
      end
    end
    pop   = (fq.size() > 0) && rd;
    k     = cmp ? key_idx(ext, c) : -1;
    push0 = cmp && !(k >= 0 && !rel && held[k]);
    if (k >= 0) held[k] = !rel;
    if (pop) void'(fq.pop_front());
    if (push0) begin
      if (fq.size() < int'(DEPTH)) fq.push_back({c, ext, rel});
      else ovf = 1;
    end
    x1_v = cmp;
    x1_e = {c, ext, rel};
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [9:0] ent;
    chk1("evt_valid", bus.EVT_VALID, fq.size() != 0);
    if (fq.size() != 0) begin
      ent = fq[0];
      chk8("evt_code", bus.EVT_CODE, ent[9:2]);
      chk1("evt_ext", bus.EVT_EXT, ent[1]);
      chk1("evt_rel", bus.EVT_REL, ent[0]);
    end
    chk1("key_left", l0, held[0]);
    chk1("key_right", r0, held[1]);
    chk1("key_fire", f0, held[2]);
    chk1("key_pause", p0, held[3]);
    chk1("overflow", ov0, ovf);
    chk1("proto_err", pe0, perr);
    chk1("nf_evt_valid", bus1.EVT_VALID, x1_v);
    if (x1_v) begin
      chk8("nf_evt_code", bus1.EVT_CODE, x1_e[9:2]);
      chk1("nf_evt_ext", bus1.EVT_EXT, x1_e[1]);
      chk1("nf_evt_rel", bus1.EVT_REL, x1_e[0]);
    end
    chk1("nf_key_fire", f1, held[2]);
    chk1("nf_overflow", ov1, 1'b0);
    chk1("nf_proto_err", pe1, perr);
  endtask

  task automatic tick(input logic v, input logic [7:0] c, input logic e, input logic r);
    bus.CODE_VALID = v;
    bus.CODE_IN    = c;
    bus.CODE_ERR   = e;
    bus.EVT_READY  = rdy;
    RESET          = r;
    if (!r) begin
      if (bus.EVT_VALID && rdy) obs0++;
      if (bus1.EVT_VALID) obs1++;
    end
    model_step(v, c, e, rdy, r);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] c);
    tick(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) tick(1'b0, 8'($urandom), 1'($urandom), 1'b0);
  endtask

  logic [7:0] burst [6] = '{8'h15, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
  logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h29, 8'h4D, 8'h15, 8'h1C};

  initial begin
    int sel;
    bus.CODE_VALID = 1'b0; bus.CODE_IN = '0; bus.CODE_ERR = 1'b0;
    rdy = 1'b0; bus.EVT_READY = 1'b0; RESET = 1'b1;

    repeat (3) tick(1'b1, 8'h29, 1'b0, 1'b1);
    chk1("reset_evt_valid", bus.EVT_VALID, 1'b0);
    chk1("reset_proto_err", pe0, 1'b0);

    // Extended press/release of LEFT, bytes 300 cycles apart.
    rdy = 1'b1;
    send(8'hE0); gap(299); send(8'h6B);
    chk1("left_set", l0, 1'b1);
    chk1("press_latency", bus.EVT_VALID, 1'b1);
    gap(299); send(8'hE0); gap(299); send(8'hF0); gap(299); send(8'h6B);
    chk1("left_clr", l0, 1'b0);
    chk8("release_evt", {5'd0, bus.EVT_VALID, bus.EVT_EXT, bus.EVT_REL}, 8'h07);
    gap(5);

    // Typematic repeats of FIRE.
    obs0 = 0; obs1 = 0;
    send(8'h29); chk1("fire_first", f0, 1'b1);
    gap(3); send(8'h29); gap(3); send(8'h29); gap(3);
    send(8'hF0); gap(3); send(8'h29);
    chk1("fire_released", f0, 1'b0);
    gap(5);
    chk8("filtered_events", 8'(obs0), 8'd2);
    chk8("unfiltered_events", 8'(obs1), 8'd4);

    // Overflow with the consumer stalled, then ordered drain.
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin send(burst[i]); gap(1); end
    chk1("overflow_set", ov0, 1'b1);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk8("drain_order", bus.EVT_CODE, burst[i]);
      gap(1);
    end
    chk1("drain_empty", bus.EVT_VALID, 1'b0);

    // Prefix timeout.
    send(8'hE0); gap(int'(TMO) - 1);
    chk1("timeout_not_early", pe0, 1'b0);
    gap(1);
    chk1("timeout_err", pe0, 1'b1);
    send(8'h74);
    chk1("timeout_right_low", r0, 1'b0);
    chk1("timeout_evt_ext", bus.EVT_EXT, 1'b0);

    // Corrupted byte after break prefix.
    gap(2); send(8'hF0); tick(1'b1, 8'h29, 1'b1, 1'b0);
    chk1("code_err_pulse", pe0, 1'b1);
    send(8'h29);
    chk1("err_fire_set", f0, 1'b1);
    chk1("err_press_rel", bus.EVT_REL, 1'b0);

    // Full FIFO with same-cycle push and pop, then reset mid-prefix.
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(burst[i]);
    rdy = 1'b1; send(8'h2B);
    chk1("push_pop_no_ovf", ov0, 1'b0);
    chk8("push_pop_head", bus.EVT_CODE, 8'h1C);
    rdy = 1'b0; gap(2); send(8'h34);
    chk1("still_full_ovf", ov0, 1'b1);
    rdy = 1'b1;
    send(8'hE0);
    tick(1'b1, 8'h6B, 1'b0, 1'b1);
    chk1("rst_evt_valid", bus.EVT_VALID, 1'b0);
    chk1("rst_overflow", ov0, 1'b0);
    send(8'h6B);
    chk1("post_rst_ext", bus.EVT_EXT, 1'b0);
    chk1("post_rst_left", l0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      sel = int'($urandom_range(0, 199));
      if (sel < 1)       tick(1'b0, 8'h00, 1'b0, 1'b1);
      else if (sel < 3)  gap(int'(TMO));
      else if (sel < 80) tick(1'b1, pool[$urandom_range(0, 9)], ($urandom_range(0, 15) == 0), 1'b0);
      else               gap(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sits directly downstream of the PS/2 keyboard receiver.
- Sequences its one-cycle byte strobes (make codes, E0 extended prefix, F0 break prefix) into complete key press/release events.
- Maintains held-key levels for the game controls (left, right, fire, pause).
- Buffers all decoded events in a small FWFT FIFO with a valid/ready handshake for the game logic.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
- TIMEOUT, 50000, CLK cycles allowed between a prefix byte and its follow-up byte before the prefix is discarded.
- FILTER_REPEAT, 1, 1 = typematic repeats of a key already held produce no FIFO event.

Ports:
- CLK  in  1  board clock.
- RESET  in  1  synchronous, active-high reset.
- CODE_VALID  in  1  one-cycle strobe: CODE_IN holds a received byte.
- CODE_IN  in  8  received scan byte.
- CODE_ERR  in  1  qualifies CODE_VALID; 1 = byte failed framing/parity.
- EVT_VALID  out  1  FIFO head holds an event.
- EVT_READY  in  1  consumer accepts the head event this cycle.
- EVT_CODE  out  8  key code of the head event.
- EVT_EXT  out  1  head event was E0-prefixed.
- EVT_REL  out  1  head event is a release (1) or press (0).
- KEY_LEFT  out  1  held level for E0 6B.
- KEY_RIGHT  out  1  held level for E0 74.
- KEY_FIRE  out  1  held level for 29 (space).
- KEY_PAUSE  out  1  held level for 4D (P).
- OVERFLOW  out  1  sticky; an event was dropped because the FIFO was full.
- PROTO_ERR  out  1  one-cycle pulse on an error byte, timeout or illegal sequence.

Behaviour:
- Reset: every output 0; FSM to IDLE; FIFO empty; timeout counter 0; OVERFLOW cleared. Reset wins over any same-cycle input.
- Bytes are acted on only when CODE_VALID=1. CODE_IN is ignored otherwise.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> complete press {ext=0, rel=0}.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT with PROTO_ERR pulse; other byte -> complete press {ext=1}, then IDLE.
  - BRK: other byte -> complete release {ext=0}, then IDLE; E0 or F0 -> PROTO_ERR, then IDLE.
  - EXT_BRK: other byte -> complete release {ext=1}, then IDLE; E0 or F0 -> PROTO_ERR, then IDLE.
- CODE_VALID with CODE_ERR=1 in any state: PROTO_ERR pulse, FSM to IDLE, byte discarded.
- Timeout:
  - The counter runs only in EXT, BRK and EXT_BRK, and resets to 0 on every accepted byte.
  - When it reaches TIMEOUT-1 without a byte: FSM to IDLE, PROTO_ERR pulse, counter cleared.
- Completion registers on the CLK edge that samples the final byte:
  - Held levels update on that edge. Mapped presses set the level; mapped releases clear it.
  - Mapping requires an exact ext match: 6B without E0 does not drive KEY_LEFT.
- Event push:
  - One event per completion.
  - When FILTER_REPEAT=1, a press of a mapped key whose level is already 1 is not pushed.
  - Unmapped keys are always pushed.
- FIFO: first-word fall-through. A pushed event appears on EVT_* with EVT_VALID=1 the cycle after the completing byte (latency 1) when the FIFO was empty.
- Pop: on EVT_VALID && EVT_READY; the next entry is presented the following cycle. EVT_READY while empty has no effect.
- Full FIFO:
  - A push with no same-cycle pop drops the new event and sets OVERFLOW.
  - A push with a same-cycle pop is accepted; count is unchanged.
- EVT_* remain stable while EVT_VALID=1 and EVT_READY=0.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is one bit wider.

Test Plan:
- E0 6B, then E0 F0 6B, strobes spaced 300 cycles apart -> KEY_LEFT 1 after the 2nd strobe and 0 after the 5th. Events {6B,ext=1,rel=0} and {6B,ext=1,rel=1}, each with EVT_VALID 1 cycle after its final byte (EVT_READY=1).
- 29 strobed three times (typematic), then F0 29, FILTER_REPEAT=1 -> KEY_FIRE held from the first strobe; exactly 2 events; repeat with FILTER_REPEAT=0 -> 4 events.
- EVT_READY=0, 6 distinct unmapped presses (15,1C,1B,23,2B,34), FIFO_DEPTH=4 -> OVERFLOW=1; then drain -> 15,1C,1B,23 in order and EVT_VALID falls after the 4th pop.
- E0, then silence for TIMEOUT cycles, then 74 -> PROTO_ERR pulse at timeout; event {74,ext=0}; KEY_RIGHT stays 0.
- F0 followed by a byte with CODE_ERR=1, then 29 -> PROTO_ERR pulse; press event {29,rel=0}; KEY_FIRE=1.
- Full FIFO with simultaneous push and pop -> push accepted, count stays 4, OVERFLOW stays 0. RESET asserted mid-sequence (state EXT) -> all outputs 0 next cycle, and a following 6B decodes with ext=0.
